// File: rtl/eq_nband_tdm.sv
// N-band FIR equalizer with per-band gain, sharing one multiply-accumulate unit.
// Samples arrive and leave on valid/ready streams; gains are double-buffered.
module eq_nband_tdm #(
    parameter int DW     = 16,
    parameter int GW     = 8,
    parameter int GFRAC  = 0,
    parameter int CW     = 16,
    parameter int CFRAC  = 15,
    parameter int NBANDS = 8,
    parameter int NTAPS  = 16
) (
    input  logic                                          t_clk,
    input  logic                                          t_rst,
    input  logic                                          s_valid,
    output logic                                          s_ready,
    input  logic signed [DW-1:0]                          s_data,
    output logic                                          m_valid,
    input  logic                                          m_ready,
    output logic signed [DW-1:0]                          m_data,
    input  logic                                          bypass,
    input  logic                                          coef_we,
    input  logic [$clog2(NBANDS*NTAPS)-1:0]               coef_addr,
    input  logic signed [CW-1:0]                          coef_data,
    input  logic                                          gain_we,
    input  logic [((NBANDS > 1) ? $clog2(NBANDS) : 1)-1:0] gain_addr,
    input  logic signed [GW-1:0]                          gain_data,
    input  logic                                          gain_commit,
    output logic                                          busy,
    output logic                                          sat_flag,
    input  logic                                          sat_clr
);

    localparam int AW   = $clog2(NBANDS*NTAPS);
    localparam int BW   = (NBANDS > 1) ? $clog2(NBANDS) : 1;
    localparam int TW   = $clog2(NTAPS);
    localparam int PW   = DW + CW;
    localparam int QW   = DW + GW;
    localparam int ACCW = DW + CW + TW;
    localparam int TOTW = DW + GW + $clog2(NBANDS);

    localparam logic signed [ACCW-1:0] CRND  = ACCW'((64'sd1 <<< CFRAC) >>> 1);
    localparam logic signed [TOTW-1:0] GRND  = TOTW'((64'sd1 <<< GFRAC) >>> 1);
    localparam logic signed [GW-1:0]   GONE  = GW'(64'sd1 <<< GFRAC);
    localparam logic signed [DW-1:0]   DMAX  = {1'b0, {(DW-1){1'b1}}};
    localparam logic signed [DW-1:0]   DMIN  = {1'b1, {(DW-1){1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MAC  = 2'd1,
        ST_GAIN = 2'd2,
        ST_OUT  = 2'd3
    } state_t;

    // Returns {clamped, value}: value is v limited to the DW-bit signed range.
    function automatic logic [DW:0] sat_dw(input logic signed [63:0] v);
        if (v > 64'(DMAX)) begin
            sat_dw = {1'b1, DMAX};
        end else if (v < 64'(DMIN)) begin
            sat_dw = {1'b1, DMIN};
        end else begin
            sat_dw = {1'b0, v[DW-1:0]};
        end
    endfunction

    state_t                 state_r, state_s;
    logic                   s_ready_r, busy_r, m_valid_r, sat_flag_r, pend_r;
    logic signed [DW-1:0]   m_data_r;
    logic signed [DW-1:0]   x_r    [NTAPS];
    logic signed [CW-1:0]   coef_r [NBANDS*NTAPS];
    logic signed [GW-1:0]   gsh_r  [NBANDS];
    logic signed [GW-1:0]   gact_r [NBANDS];
    logic signed [ACCW-1:0] acc_r;
    logic signed [TOTW-1:0] total_r;
    logic [BW-1:0]          band_r;
    logic [TW-1:0]          tap_r;

    logic                   accept_s, last_tap_s, last_band_s, sat_set_s;
    logic [AW-1:0]          cidx_s;
    logic signed [PW-1:0]   prod_s;
    logic signed [ACCW-1:0] acc_nxt_s, bsh_s;
    logic [DW:0]            bsat_s, fsat_s;
    logic signed [DW-1:0]   bo_s;
    logic signed [QW-1:0]   gprod_s;
    logic signed [TOTW-1:0] tot_nxt_s, fsh_s;

    assign s_ready  = s_ready_r;
    assign busy     = busy_r;
    assign m_valid  = m_valid_r;
    assign m_data   = m_data_r;
    assign sat_flag = sat_flag_r;

    // Datapath arithmetic: MAC product, band rounding/clamp, gain and final rounding/clamp.
    always_comb begin
        accept_s    = s_valid && s_ready_r;
        last_tap_s  = (tap_r == TW'(NTAPS - 1));
        last_band_s = (band_r == BW'(NBANDS - 1));
        cidx_s      = AW'(band_r) * AW'(NTAPS) + AW'(tap_r);
        prod_s      = x_r[tap_r] * coef_r[cidx_s];
        acc_nxt_s   = acc_r + ACCW'(prod_s);
        bsh_s       = (acc_r + CRND) >>> CFRAC;
        bsat_s      = sat_dw(64'(bsh_s));
        bo_s        = signed'(bsat_s[DW-1:0]);
        gprod_s     = bo_s * gact_r[band_r];
        tot_nxt_s   = total_r + TOTW'(gprod_s);
        fsh_s       = (tot_nxt_s + GRND) >>> GFRAC;
        fsat_s      = sat_dw(64'(fsh_s));
        sat_set_s   = (state_r == ST_GAIN) && (bsat_s[DW] || (last_band_s && fsat_s[DW]));
    end

    // Next-state logic for the sample sequencer.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_s = bypass ? ST_OUT : ST_MAC;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_MAC:  state_s = last_tap_s ? ST_GAIN : ST_MAC;
            ST_GAIN: state_s = last_band_s ? ST_OUT : ST_MAC;
            ST_OUT:  state_s = m_ready ? ST_IDLE : ST_OUT;
            default: state_s = ST_IDLE;
        endcase
    end

    // State register with registered handshake/status decodes.
    always_ff @(posedge t_clk or negedge t_rst) begin
        if (!t_rst) begin
            state_r   <= ST_IDLE;
            s_ready_r <= 1'b1;
            busy_r    <= 1'b0;
            m_valid_r <= 1'b0;
        end else begin
            state_r   <= state_s;
            s_ready_r <= (state_s == ST_IDLE);
            busy_r    <= (state_s != ST_IDLE);
            m_valid_r <= (state_s == ST_OUT);
        end
    end

    // Delay line; it shifts on every accepted sample, bypassed or not.
    always_ff @(posedge t_clk or negedge t_rst) begin
        if (!t_rst) begin
            for (int i = 0; i < NTAPS; i++) x_r[i] <= '0;
        end else if (accept_s) begin
            x_r[0] <= s_data;
            for (int i = 1; i < NTAPS; i++) x_r[i] <= x_r[i-1];
        end
    end

    // Coefficient store; writes while a sample is in flight are dropped.
    always_ff @(posedge t_clk or negedge t_rst) begin
        if (!t_rst) begin
            for (int i = 0; i < NBANDS*NTAPS; i++) coef_r[i] <= '0;
        end else if (coef_we && !busy_r) begin
            coef_r[coef_addr] <= coef_data;
        end
    end

    // Shadow/active gains; the copy reads shadow values from before any same-cycle write.
    always_ff @(posedge t_clk or negedge t_rst) begin
        if (!t_rst) begin
            for (int i = 0; i < NBANDS; i++) begin
                gsh_r[i]  <= GONE;
                gact_r[i] <= GONE;
            end
            pend_r <= 1'b0;
        end else begin
            if (gain_we) gsh_r[gain_addr] <= gain_data;
            if (accept_s) begin
                if (pend_r || gain_commit) begin
                    for (int i = 0; i < NBANDS; i++) gact_r[i] <= gsh_r[i];
                end
                pend_r <= 1'b0;
            end else if (gain_commit) begin
                pend_r <= 1'b1;
            end
        end
    end

    // Accumulators and band/tap counters.
    always_ff @(posedge t_clk or negedge t_rst) begin
        if (!t_rst) begin
            acc_r   <= '0;
            total_r <= '0;
            band_r  <= '0;
            tap_r   <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        acc_r   <= '0;
                        total_r <= '0;
                        band_r  <= '0;
                        tap_r   <= '0;
                    end
                end
                ST_MAC: begin
                    acc_r <= acc_nxt_s;
                    tap_r <= tap_r + TW'(1);
                end
                ST_GAIN: begin
                    acc_r   <= '0;
                    tap_r   <= '0;
                    total_r <= tot_nxt_s;
                    if (!last_band_s) band_r <= band_r + BW'(1);
                end
                default: begin
                    acc_r <= acc_r;
                end
            endcase
        end
    end

    // Output sample register and sticky saturation flag (set beats clear).
    always_ff @(posedge t_clk or negedge t_rst) begin
        if (!t_rst) begin
            m_data_r   <= '0;
            sat_flag_r <= 1'b0;
        end else begin
            if (state_r == ST_IDLE && accept_s && bypass) begin
                m_data_r <= s_data;
            end else if (state_r == ST_GAIN && last_band_s) begin
                m_data_r <= signed'(fsat_s[DW-1:0]);
            end
            if (sat_set_s) begin
                sat_flag_r <= 1'b1;
            end else if (sat_clr) begin
                sat_flag_r <= 1'b0;
            end
        end
    end

endmodule

// File: doc/eq_nband_tdm.md
Name: eq_nband_tdm

Overview:
Parametrised successor to the fixed 8-band equalizer. It implements NBANDS FIR band filters, each NTAPS taps long, plus a per-band gain. All of this runs on one time-multiplexed multiply-accumulate unit. Samples enter and leave through valid/ready streams. Coefficients are runtime-programmable, and gains are double-buffered with a glitch-free commit. The block sits between the audio sample source and the output sink, and the 16-bit/8-bit testbench configuration is its default instance.

Parameters:
DW, 16, sample width (signed)
GW, 8, gain width (signed, Q with GFRAC fractional bits)
GFRAC, 0, gain fractional bits
CW, 16, coefficient width (signed)
CFRAC, 15, coefficient fractional bits
NBANDS, 8, number of bands (>=1)
NTAPS, 16, taps per band (>=2)

Ports:
t_clk  in  1  clock, rising edge
t_rst  in  1  asynchronous reset, active-low
s_valid  in  1  input sample valid
s_ready  out  1  block can accept a sample
s_data  in  DW  signed input sample
m_valid  out  1  output sample valid
m_ready  in  1  sink accepts output
m_data  out  DW  signed equalized output
bypass  in  1  sampled at accept; 1 = pass input straight through
coef_we  in  1  coefficient write strobe
coef_addr  in  clog2(NBANDS*NTAPS)  band*NTAPS+tap
coef_data  in  CW  coefficient value
gain_we  in  1  shadow gain write strobe
gain_addr  in  clog2(NBANDS)  band index
gain_data  in  GW  gain value
gain_commit  in  1  pulse: schedule shadow->active copy
busy  out  1  state != IDLE
sat_flag  out  1  sticky saturation indicator
sat_clr  in  1  clear sat_flag

Behaviour:
- Reset (t_rst=0, async): state=IDLE; s_ready=1; m_valid=0; m_data=0; sat_flag=0; busy=0; delay line=0; all coefs=0; shadow and active gains=1<<GFRAC; commit_pending=0.
- FSM states IDLE, MAC, GAIN, OUT.
- IDLE: s_ready=1. Accept happens when s_valid&&s_ready. On accept:
  - shift s_data into x[0]; x[i]<=x[i-1].
  - If commit_pending or gain_commit is high that cycle, copy shadow->active and clear pending. A gain_we in the accept cycle is excluded from the copy.
  - bypass=1: go to OUT with m_data=s_data.
  - Otherwise: band=0, tap=0, acc=0, total=0; go to MAC.
- MAC: one product per cycle, acc += x[tap]*coef[band][tap]. At tap==NTAPS-1, go to GAIN.
- GAIN: compute bo = sat_DW((acc + 2^(CFRAC-1)) >>> CFRAC), then total += bo*gain_act[band].
  - Clear acc and tap.
  - If band==NBANDS-1, go to OUT, else band++ and return to MAC.
- OUT: m_data = sat_DW((total + (GFRAC?2^(GFRAC-1):0)) >>> GFRAC); m_valid=1.
  - m_data is held stable while m_ready=0.
  - On m_valid&&m_ready, go to IDLE (m_valid=0 next cycle).
  - s_ready=0 in all states except IDLE.
- Latency from accept edge to m_valid high: NBANDS*(NTAPS+1)+1 cycles (137 by default); bypass latency is 1 cycle.
- Width rules:
  - acc width is DW+CW+clog2(NTAPS).
  - total width is DW+GW+clog2(NBANDS).
  - Arithmetic is signed with an arithmetic shift; rounding is round-half-up.
  - sat_DW clamps to [-2^(DW-1), 2^(DW-1)-1]. Any clamp event, at band or final stage, sets sat_flag.
  - sat_flag holds until sat_clr. If sat_clr and a new clamp occur in the same cycle, the set wins.
- coef_we is honoured only when busy=0 and is silently dropped otherwise.
- gain_we writes the shadow register at any time.
- gain_commit while busy sets commit_pending; the copy happens at the next accept.
- Mid-operation reset aborts the sample: no m_valid, and all state and config return to reset values.
- The delay line shifts on bypassed samples as well.

Test Plan:
1. Assert t_rst=0 for 3 cycles, then release -> m_valid=0, m_data=0, s_ready=1, busy=0, sat_flag=0.
2. coef[0][0]=16384, default gains (1); send s_data=1000 -> m_data=500 exactly 137 cycles after accept. Then gain0=2 via gain_we plus gain_commit, send 1000 -> m_data=1000.
3. After reset, coef[1][3]=16384; send impulse 2000 then zeros -> outputs 0,0,0,1000,0,0.
4. coef[0][0]=32767, gain0=4; send 30000 -> m_data=32767, sat_flag=1. Send -30000 -> m_data=-32768. Pulse sat_clr -> sat_flag=0.
5. Hold m_ready=0 for 20 cycles in OUT -> m_data stable, s_ready=0, s_valid ignored. A coef_we during MAC is dropped and the output is unchanged. A gain_commit during MAC affects only the next sample.
6. bypass=1 with s_data=-1234 -> m_data=-1234 one cycle after accept. Reset asserted during MAC (cycle 50) -> m_valid never rises, coefs read back as 0 (next output 0).
